// File: rtl/ps2_key_event_decoder.sv
// PS/2 keyboard front end: synchronises the raw PS/2 lines, validates 11-bit
// frames, folds E0/F0 prefixes into make/break key events, queues them in a
// FWFT FIFO with a valid/ready handshake, and keeps the legacy game-control
// decode (direction / fire / done).
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [1:0] direction,
    output logic       fire,
    output logic       done,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q, fe_q, bit_q;

    // Frame FSM
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           timeout;
    logic           err_d, byte_valid_d;
    logic           byte_valid_q;
    logic [7:0]     byte_q;

    // Prefix tracker, legacy decode
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       push;
    logic [1:0] dir_d;
    logic       fire_d, done_d;

    // Event FIFO
    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, pop, wr_en, ovf_d;

    // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a
    // phantom falling edge straight out of reset. fe_q is a one-cycle pulse
    // with bit_q carrying the data level sampled alongside it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fe_q        <= 1'b0;
            bit_q       <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            fe_q        <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            bit_q       <= data_sync_q[SYNC_STAGES-1];
        end
    end

    // Inter-edge watchdog only matters once a start bit has been accepted.
    assign timeout  = (state_q != S_IDLE) && !fe_q && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign to_cnt_d = (fe_q || state_q == S_IDLE) ? '0 : to_cnt_q + TW'(1);

    // Frame FSM next state: shift data LSB first, check parity/stop at the end.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        err_d        = 1'b0;
        byte_valid_d = 1'b0;
        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (fe_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!bit_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {bit_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_d = bit_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (bit_q && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                    else                                 err_d        = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Frame FSM state and datapath registers; completed byte is staged one cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            frame_err    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            frame_err    <= err_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= shift_q;
        end
    end

    // Prefix tracking and legacy decode; the decode ignores FIFO back-pressure.
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        push   = 1'b0;
        dir_d  = direction;
        fire_d = 1'b0;
        done_d = 1'b0;
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid_q) begin
            case (byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    push  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
        if (push && !brk_q) begin
            if (byte_q == 8'h29 || byte_q == 8'h5A) begin
                fire_d = 1'b1;
                done_d = 1'b1;
            end else if (!ext_q) begin
                case (byte_q)
                    8'h1D: begin dir_d = 2'b00; done_d = 1'b1; end
                    8'h1B: begin dir_d = 2'b01; done_d = 1'b1; end
                    8'h1C: begin dir_d = 2'b10; done_d = 1'b1; end
                    8'h23: begin dir_d = 2'b11; done_d = 1'b1; end
                    default: ;
                endcase
            end else begin
                case (byte_q)
                    8'h75: begin dir_d = 2'b00; done_d = 1'b1; end
                    8'h72: begin dir_d = 2'b01; done_d = 1'b1; end
                    8'h6B: begin dir_d = 2'b10; done_d = 1'b1; end
                    8'h74: begin dir_d = 2'b11; done_d = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    // FIFO status: extra pointer bit separates full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && evt_ready;
    assign wr_en = push && (!full || pop);
    assign ovf_d = push && full && !pop;

    assign evt_valid = !empty;
    assign {evt_code, evt_ext, evt_break} = mem_q[rd_ptr_q[AW-1:0]];

    // Prefix flags, legacy outputs, FIFO storage and pointers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            direction <= 2'b11;
            fire      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 10'h000;
        end else begin
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            direction <= dir_d;
            fire      <= fire_d;
            done      <= done_d;
            overflow  <= ovf_d;
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {byte_q, ext_q, brk_q};
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/ps2_key_event_decoder.md
# ps2_key_event_decoder

Parametrised successor to the PS/2 keyboard front end. It oversamples `ps2_clk`/`ps2_data` in the `sys_clk` domain and validates each 11-bit frame (start, parity, stop, inter-bit timeout). It tracks E0/F0 prefixes and pushes complete make/break key events into a FIFO with a valid/ready handshake for the processor. The legacy `direction`/`fire`/`done` outputs are kept so the game-control path is unchanged.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries; power of 2, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops on `ps2_clk` and `ps2_data`; ≥2.
- `TIMEOUT_CYCLES`, 5000: `sys_clk` cycles allowed between falling PS/2 clock edges inside a frame; ≥2.
- `sys_clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `evt_valid`  out  1  FIFO head is valid.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `evt_code`  out  8  scan code at the head.
- `evt_ext`  out  1  head event was E0-prefixed.
- `evt_break`  out  1  head event was F0-prefixed (key release).
- `direction`  out  2  last direction make: 00 up, 01 down, 10 left, 11 right.
- `fire`  out  1  one-cycle pulse on a space or enter make.
- `done`  out  1  one-cycle pulse on any direction or fire make.
- `frame_err`  out  1  one-cycle pulse on a parity, stop or timeout error.
- `overflow`  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Both inputs pass through `SYNC_STAGES` flops. A falling edge (`fe`) is synced clock previous 1, now 0. Data is sampled from the synced data on `fe`.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fe` with data 0, go to DATA with bit count 0. On `fe` with data 1, stay in IDLE and drop the edge silently.
  - DATA: shift in LSB first. After 8 bits, go to PARITY.
  - PARITY: capture the parity bit. Then go to STOP.
  - STOP: on `fe`, the frame is valid if data is 1 and the 8 data bits plus parity have odd popcount. Otherwise pulse `frame_err`. Return to IDLE either way.
- Timeout: a counter resets on every `fe` and runs while the FSM is not in IDLE. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, return to IDLE and clear the prefix flags.
- Prefix tracker: flags `ext` and `brk`, applied to each valid byte.
  - E0 sets `ext`. F0 sets `brk`.
  - 00, AA, E1, FA, FE and FF are dropped and clear both flags.
  - Any other code emits the event {code, `ext`, `brk`} and clears both flags.
  - Any `frame_err` clears both flags.
- FIFO: first-word-fall-through, `FIFO_DEPTH` entries of 10 bits.
  - Pop when `evt_valid & evt_ready`. `evt_ready` with an empty FIFO does nothing.
  - Push while full with no pop: the event is dropped and `overflow` pulses.
  - Push while full with a simultaneous pop: both complete and there is no overflow.
  - Pointers wrap modulo `FIFO_DEPTH`, with an extra bit to tell full from empty.
- Legacy decode runs only on emitted make events (`brk` = 0). It runs even when the FIFO drops the event.
  - `ext` = 0: 1D→00, 1B→01, 1C→10, 23→11.
  - `ext` = 1: 75→00, 72→01, 6B→10, 74→11.
  - A match updates `direction` and pulses `done`.
  - 29 (any `ext`) or 5A (any `ext`) pulses `fire` and `done` and leaves `direction` unchanged.
  - Break events and unmapped codes change nothing.

## Timing
- Reset values: FSM IDLE, flags 0, FIFO empty, `evt_valid` 0, `evt_code` 00, `evt_ext` 0, `evt_break` 0, `direction` 11, and `fire`, `done`, `frame_err`, `overflow` all 0. Reset mid-frame discards all partial state.
- An edge at the pins produces `fe` SYNC_STAGES+1 cycles later.
- Let the stop-bit `fe` be cycle T:
  - decode and FIFO write occur at the clock edge ending cycle T+1;
  - `evt_valid` rises in T+2 if the FIFO was empty;
  - `direction`, `fire`, `done` and `overflow` are registered and assert in T+2 for exactly one cycle.
- `frame_err` asserts the cycle after the failing `fe`, or the cycle after the timeout count is reached.
- `evt_*` hold stable while `evt_valid & ~evt_ready`.
- Pop then next head: the new head is visible the cycle after the pop.
- Minimum PS/2 half-period must exceed SYNC_STAGES+2 `sys_clk` cycles.

## Test plan
- Frame 1D with correct parity:
  - one event {1D, 0, 0}, `evt_valid` at T+2;
  - `direction` goes 11→00;
  - `done` pulses once and `fire` does not pulse.
- E0 74, then E0 F0 74:
  - events {74, 1, 0} and {74, 1, 1};
  - `direction` = 11;
  - `done` pulses only for the first event.
- Frame 29 with the parity bit flipped:
  - `frame_err` pulses once;
  - no event, no `fire`.
- Start bit and 4 data bits, then clock idle for `TIMEOUT_CYCLES`:
  - `frame_err` pulses;
  - a following valid 1B frame decodes normally: `direction` 01, event {1B, 0, 0}.
- With `evt_ready` = 0, send FIFO_DEPTH+1 makes of 5A:
  - `fire` pulses FIFO_DEPTH+1 times;
  - `overflow` pulses once;
  - draining returns exactly FIFO_DEPTH events of {5A, 0, 0}.
- FIFO full, with `evt_ready` high during the cycle a new event is written:
  - no `overflow`;
  - the FIFO stays full;
  - drain order is preserved.
